// File: rtl/button_input.sv
`default_nettype none
// ============================================================================
// Module   : button_input
// Purpose  : Memory-mapped active-low button peripheral: synchronise, debounce,
//            latch press events, expose STATE/PRESS/IRQ_EN, drive a level irq.
// Revision : 1.0 - initial release
// ============================================================================
module button_input #(
    parameter logic [31:0] DEVICE_START_ADDRESS = 32'h00001010,
    parameter logic [31:0] DEVICE_FINAL_ADDRESS = 32'h0000101C,
    parameter int          WIDTH                = 8,
    parameter int          DEBOUNCE_CYCLES      = 10000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      address,
    input  logic [31:0]      write_data,
    output logic [31:0]      read_data,
    output logic             response,
    input  logic [WIDTH-1:0] buttons_n,
    output logic             irq
);

    localparam int                 c_CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]         c_REG_STATE  = 2'd0;
    localparam logic [1:0]         c_REG_PRESS  = 2'd1;
    localparam logic [1:0]         c_REG_IRQ_EN = 2'd2;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_press;
    logic [WIDTH-1:0] r_irq_en;

    logic [WIDTH-1:0] w_pressed;
    logic [WIDTH-1:0] w_differ;
    logic [WIDTH-1:0] w_toggle;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr_press;
    logic             w_wr_irq_en;
    logic [31:0]      w_rd_data;
    logic             w_unused_ok;

    // Window decode happens upstream; these inputs are intentionally ignored.
    assign w_unused_ok = ^{DEVICE_START_ADDRESS, DEVICE_FINAL_ADDRESS,
                           address[31:4], address[1:0], write_data};

    assign w_pressed   = ~r_sync2;
    assign w_differ    = w_pressed ^ r_state;
    assign w_rise      = w_toggle & w_pressed;
    assign w_wr_press  = write && (address[3:2] == c_REG_PRESS);
    assign w_wr_irq_en = write && (address[3:2] == c_REG_IRQ_EN);
    assign w_clr       = w_wr_press ? write_data[WIDTH-1:0] : '0;

    // Counter saturates implicitly: it is cleared on acceptance before it could wrap.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            logic [c_CNT_W-1:0] r_cnt;

            assign w_toggle[i] = w_differ[i] && (r_cnt == c_CNT_MAX);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (!w_differ[i] || w_toggle[i]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_state  <= '0;
            r_press  <= '0;
            r_irq_en <= '0;
            irq      <= 1'b0;
        end else begin
            r_sync1 <= buttons_n;
            r_sync2 <= r_sync1;
            r_state <= r_state ^ w_toggle;
            // A new press outranks a simultaneous clear of the same bit.
            r_press <= (r_press & ~w_clr) | w_rise;
            if (w_wr_irq_en) begin
                r_irq_en <= write_data[WIDTH-1:0];
            end
            irq <= |(r_press & r_irq_en);
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (address[3:2])
            c_REG_STATE:  w_rd_data[WIDTH-1:0] = r_state;
            c_REG_PRESS:  w_rd_data[WIDTH-1:0] = r_press;
            c_REG_IRQ_EN: w_rd_data[WIDTH-1:0] = r_irq_en;
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            response  <= 1'b0;
            read_data <= '0;
        end else begin
            response  <= read || write;
            read_data <= (read && !write) ? w_rd_data : '0;
        end
    end

endmodule
`default_nettype wire
